// File: rtl/px_out_fifo_if.sv
// rtl/px_out_fifo_if.sv - pixel push/pop and status bundle for px_out_fifo.
// slave is the FIFO side; master is the producer/consumer side.
`ifndef MAX_PIXEL_BITS
`define MAX_PIXEL_BITS 24
`endif

interface px_out_fifo_if #(
   parameter int DATA_W = `MAX_PIXEL_BITS,
   parameter int DEPTH  = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              px_rdy_i;
   logic [DATA_W-1:0] px_i;
   logic              rd_req_i;
   logic              clr_i;
   logic [DATA_W-1:0] px_o;
   logic              px_rdy_o;
   logic              empty_o;
   logic              full_o;
   logic [LW-1:0]     level_o;
   logic              overflow_o;
   logic [7:0]        drop_cnt_o;

   modport slave (
      input  px_rdy_i, px_i, rd_req_i, clr_i,
      output px_o, px_rdy_o, empty_o, full_o, level_o, overflow_o, drop_cnt_o
   );

   modport master (
      output px_rdy_i, px_i, rd_req_i, clr_i,
      input  px_o, px_rdy_o, empty_o, full_o, level_o, overflow_o, drop_cnt_o
   );
endinterface

// File: rtl/px_out_fifo.sv
// rtl/px_out_fifo.sv - circular pixel FIFO with registered pop output and sticky overflow.
// Optional saturating dropped-push counter built only with PX_OUT_FIFO_DROP_CNT_EN.
`ifndef MAX_PIXEL_BITS
`define MAX_PIXEL_BITS 24
`endif

module px_out_fifo #(
   parameter int DATA_W = `MAX_PIXEL_BITS,
   parameter int DEPTH  = 8
) (
   input  logic          clk_i,
   input  logic          nreset_i,
   px_out_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [DATA_W-1:0] px_q, px_d;
   logic              px_rdy_q, px_rdy_d;
   logic              ovf_q, ovf_d;

   logic              pop_req;
   logic              push_fits;
   logic              pop_acc;
   logic              push_acc;
   logic              push_drop;

   // A pop frees a slot in the same cycle, so a push at full still fits; at empty there is no bypass.
   always_comb begin
      pop_req   = bus.rd_req_i && (level_q != '0);
      push_fits = (level_q != LVL_FULL) || pop_req;
      pop_acc   = pop_req && !bus.clr_i;
      push_acc  = bus.px_rdy_i && push_fits && !bus.clr_i;
      push_drop = bus.px_rdy_i && !push_fits && !bus.clr_i;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      px_d     = px_q;
      px_rdy_d = 1'b0;
      ovf_d    = ovf_q;
      if (bus.clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            px_d     = mem_q[rd_ptr_q];
            px_rdy_d = 1'b1;
         end
         level_d = level_q + LW'(push_acc) - LW'(pop_acc);
         if (push_drop) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         px_q     <= '0;
         px_rdy_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         px_q     <= px_d;
         px_rdy_q <= px_rdy_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; only the pointers and level decide what is valid.
   always_ff @(posedge clk_i) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= bus.px_i;
      end
   end

`ifdef PX_OUT_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (bus.clr_i) begin
         drop_cnt_d = '0;
      end else if (push_drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.drop_cnt_o = drop_cnt_q;
`else
   assign bus.drop_cnt_o = '0;
`endif

   assign bus.px_o       = px_q;
   assign bus.px_rdy_o   = px_rdy_q;
   assign bus.empty_o    = (level_q == '0);
   assign bus.full_o     = (level_q == LVL_FULL);
   assign bus.level_o    = level_q;
   assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_px_out_fifo.sv
// tb/tb_px_out_fifo.sv - directed scoreboard bench for px_out_fifo (DATA_W=24, DEPTH=8).
module tb_px_out_fifo;
   localparam int DW = 24;
   localparam int DP = 8;

   logic clk_i;
   logic nreset_i;

   px_out_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bif ();

   px_out_fifo #(.DATA_W(DW), .DEPTH(DP)) u_dut (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .bus      (bif)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int          vectors;
   int          miscompares;
   logic [23:0] mdl[$];
   logic [23:0] exp_q[$];
   logic [23:0] last_px;
   bit          m_ovf;
   int          m_drops;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      int exp_drop;
`ifdef PX_OUT_FIFO_DROP_CNT_EN
      exp_drop = m_drops;
`else
      exp_drop = 0;
`endif
      chk("level", 32'(bif.level_o), 32'(mdl.size()));
      chk("empty", 32'(bif.empty_o), 32'(mdl.size() == 0));
      chk("full", 32'(bif.full_o), 32'(mdl.size() == DP));
      chk("overflow", 32'(bif.overflow_o), 32'(m_ovf));
      chk("drop_cnt", 32'(bif.drop_cnt_o), 32'(exp_drop));
   endtask

   task automatic step(input bit push, input logic [23:0] d, input bit pop, input bit clr);
      bit pop_ok;
      bit push_ok;
      bif.px_rdy_i = push;
      bif.px_i     = d;
      bif.rd_req_i = pop;
      bif.clr_i    = clr;
      pop_ok  = 1'b0;
      push_ok = 1'b0;
      if (clr) begin
         mdl.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         pop_ok  = pop && (mdl.size() > 0);
         push_ok = push && ((mdl.size() < DP) || pop_ok);
         if (pop_ok) exp_q.push_back(mdl.pop_front());
         if (push_ok) mdl.push_back(d);
         if (push && !push_ok) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
      end
      @(posedge clk_i);
      #1;
      bif.px_rdy_i = 1'b0;
      bif.rd_req_i = 1'b0;
      bif.clr_i    = 1'b0;
      chk("px_rdy", 32'(bif.px_rdy_o), 32'(pop_ok));
      if (pop_ok) last_px = exp_q.pop_front();
      chk("px_o", 32'(bif.px_o), 32'(last_px));
      chk_status();
   endtask

   task automatic chk_reset_vals();
      chk("rst_px_o", 32'(bif.px_o), 32'h0);
      chk("rst_px_rdy", 32'(bif.px_rdy_o), 32'h0);
      chk("rst_level", 32'(bif.level_o), 32'h0);
      chk("rst_empty", 32'(bif.empty_o), 32'h1);
      chk("rst_full", 32'(bif.full_o), 32'h0);
      chk("rst_overflow", 32'(bif.overflow_o), 32'h0);
      chk("rst_drop_cnt", 32'(bif.drop_cnt_o), 32'h0);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      last_px      = '0;
      m_ovf        = 1'b0;
      m_drops      = 0;
      bif.px_rdy_i = 1'b0;
      bif.px_i     = '0;
      bif.rd_req_i = 1'b0;
      bif.clr_i    = 1'b0;
      nreset_i     = 1'b0;

      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_vals();
      #3 nreset_i = 1'b1;

      // basic order and latency
      for (int i = 1; i <= 3; i++) step(1'b1, 24'(i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         step(1'b0, '0, 1'b0, 1'b0);
      end

      // pop at empty is ignored
      step(1'b0, '0, 1'b1, 1'b0);

      // overflow: 10 pushes, 2 dropped
      for (int i = 0; i < 10; i++) step(1'b1, 24'h000100 + 24'(i), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

      // push and pop together at full
      for (int i = 0; i < 8; i++) step(1'b1, 24'h000200 + 24'(i), 1'b0, 1'b0);
      step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

      // push and pop together at empty: no bypass
      step(1'b1, 24'h123456, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // clear has priority
      for (int i = 0; i < 5; i++) step(1'b1, 24'h000300 + 24'(i), 1'b0, 1'b0);
      step(1'b1, 24'h0BAD00, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);

      // random traffic with pointer wrap, then asynchronous reset mid-stream
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 24'h000400 + 24'(i), 1'b0, 1'b0);
      #2 nreset_i = 1'b0;
      #1;
      chk_reset_vals();
      mdl.delete();
      exp_q.delete();
      last_px = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
      #3 nreset_i = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 24'h000500 + 24'(i), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/px_out_fifo.md
PX_OUT_FIFO -- requirements
Module: px_out_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default MAX_PIXEL_BITS, pixel word width.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port nreset_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port px_rdy_i, input, 1 bit: one-cycle pulse meaning px_i is valid (producer: top_gray_sobel px_rdy_o).
REQ-006 SHALL have port px_i, input, DATA_W bits: pixel to push.
REQ-007 SHALL have port rd_req_i, input, 1 bit: one-cycle pop request from spi_control side.
REQ-008 SHALL have port clr_i, input, 1 bit: synchronous flush.
REQ-009 SHALL have port px_o, output, DATA_W bits: last popped pixel, registered.
REQ-010 SHALL have port px_rdy_o, output, 1 bit: one-cycle pulse when px_o is updated.
REQ-011 SHALL have port empty_o, output, 1 bit: level == 0.
REQ-012 SHALL have port full_o, output, 1 bit: level == DEPTH.
REQ-013 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky, set when a push is dropped.
REQ-015 SHALL have port drop_cnt_o, output, 8 bits: dropped-push count (see Configuration).

Function
REQ-016 SHALL be a circular buffer with write/read pointers that wrap modulo DEPTH, and a separate level counter.
REQ-017 Push SHALL be accepted when px_rdy_i=1 and (level<DEPTH or a pop is accepted in the same cycle); px_i is stored at the write pointer, which advances by 1.
REQ-018 Pop SHALL be accepted when rd_req_i=1 and level>0; the head entry appears on px_o and px_rdy_o=1 in the next cycle (latency 1); the read pointer advances by 1.
REQ-019 rd_req_i with level==0 SHALL be ignored: no px_rdy_o, px_o holds, no error flag.
REQ-020 Simultaneous push and pop at full SHALL both be accepted; level is unchanged.
REQ-021 Simultaneous push and pop at empty SHALL accept only the push (no fall-through bypass); level becomes 1.
REQ-022 A push while full with no pop SHALL be dropped; overflow_o goes to 1 the next cycle and stays 1 until clr_i or reset.
REQ-023 clr_i SHALL have priority over push and pop in the same cycle: pointers, level and overflow_o become 0 and drop_cnt_o is cleared; px_o holds its value; px_rdy_o=0.
REQ-024 px_o SHALL change only on an accepted pop.
REQ-025 Status outputs (empty_o, full_o, level_o) SHALL reflect registered state and update one cycle after the causing event.
REQ-026 Storage contents SHALL need no reset; only pointers, level, flags and outputs are reset.

Reset
REQ-027 nreset_i low SHALL asynchronously force: pointers=0, level_o=0, empty_o=1, full_o=0, px_o=0, px_rdy_o=0, overflow_o=0, drop_cnt_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered pixels; the first cycle after release behaves as empty.
REQ-029 The instantiating parent SHALL drive nreset_i from its synchronized reset (spi_dep_async_nreset_synchronizer output).

Configuration
REQ-030 Macro PX_OUT_FIFO_DROP_CNT_EN defined: drop_cnt_o SHALL increment by 1 per dropped push, saturate at 255, and clear on clr_i or reset.
REQ-031 Macro PX_OUT_FIFO_DROP_CNT_EN undefined: drop_cnt_o SHALL be tied to 0 and no counter logic is built; all other behaviour is identical.

Verification (DATA_W=24, DEPTH=8)
REQ-032 Push 0x000001..0x000003 on separate cycles, then 3 rd_req_i pulses -> px_o=0x000001,0x000002,0x000003, each with a 1-cycle px_rdy_o exactly 1 cycle after its request; empty_o=1 at the end.
REQ-033 Push 10 pixels with no pops -> full_o=1, level_o=8, overflow_o=1; with the macro, drop_cnt_o=2; pops return the first 8 pixels in order.
REQ-034 At full, push 0xABCDEF together with a pop -> level_o stays 8, pop returns the oldest entry, and 0xABCDEF is read out 8 pops later.
REQ-035 At empty, push 0x123456 together with rd_req_i -> no px_rdy_o, level_o=1; the next pop returns 0x123456.
REQ-036 Fill 5 pixels, then clr_i together with px_rdy_i and rd_req_i -> level_o=0, overflow_o=0, px_o unchanged, no px_rdy_o.
REQ-037 Drive 20 push/pop cycles covering pointer wrap, assert nreset_i mid-stream -> all outputs take their reset values immediately, without waiting for a clock edge; afterwards 8 pushes and 8 pops return correct data.
